// File: rtl/prf_pkg.sv
// Shared types and defaults for the physical register file.
package prf_pkg;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned NUM_REGS_DEF   = 64;
  localparam int unsigned ADDR_W_DEF     = $clog2(NUM_REGS_DEF);
  localparam int unsigned PREG_ZERO      = 0;

  typedef logic [ADDR_W_DEF-1:0]     preg_idx_t;
  typedef logic [DATA_WIDTH_DEF-1:0] preg_data_t;
endpackage

// File: rtl/prf_read_port.sv
// One registered read port of the PRF: zero-register override, enable gating,
// and (with PRF_WR_BYPASS_EN) same-cycle writeback forwarding.
module prf_read_port
  import prf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  input  logic [DATA_WIDTH-1:0] arr_data_i,
  input  logic                  arr_ready_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  alloc_en_i,
  input  logic [ADDR_W-1:0]     alloc_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_ready_o
);

  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_ready;

`ifdef PRF_WR_BYPASS_EN
  always_comb begin
    w_data  = arr_data_i;
    w_ready = arr_ready_i;
    // Forward writeback data; a same-cycle alloc of the index still clears ready.
    if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      w_data  = wr_data_i;
      w_ready = !(alloc_en_i && (alloc_addr_i == rd_addr_i));
    end
    if (rd_addr_i == ADDR_W'(PREG_ZERO)) begin
      w_data  = '0;
      w_ready = 1'b1;
    end
  end
`else
  logic w_unused_bypass;
  assign w_unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i};

  always_comb begin
    w_data  = arr_data_i;
    w_ready = arr_ready_i;
    if (rd_addr_i == ADDR_W'(PREG_ZERO)) begin
      w_data  = '0;
      w_ready = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_o  <= '0;
      rd_ready_o <= 1'b0;
    end else if (rd_en_i) begin
      rd_data_o  <= w_data;
      rd_ready_o <= w_ready;
    end else begin
      rd_data_o  <= '0;
      rd_ready_o <= 1'b0;
    end
  end

endmodule

// File: rtl/prf_1w_3r.sv
// Physical register file: one writeback port, three registered read ports, per-register
// ready bits. Define PRF_WR_BYPASS_EN to forward same-cycle writeback to reads.
module prf_1w_3r
  import prf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
  parameter int unsigned ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  alloc_en_i,
  input  logic [ADDR_W-1:0]     alloc_addr_i,
  input  logic                  rd1_en_i,
  input  logic [ADDR_W-1:0]     rd1_addr_i,
  output logic [DATA_WIDTH-1:0] rd1_data_o,
  output logic                  rd1_ready_o,
  input  logic                  rd2_en_i,
  input  logic [ADDR_W-1:0]     rd2_addr_i,
  output logic [DATA_WIDTH-1:0] rd2_data_o,
  output logic                  rd2_ready_o,
  input  logic                  rd3_en_i,
  input  logic [ADDR_W-1:0]     rd3_addr_i,
  output logic [DATA_WIDTH-1:0] rd3_data_o,
  output logic                  rd3_ready_o
);

  localparam int unsigned NUM_RD = 3;

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
  logic [NUM_REGS-1:0]   r_ready;

  logic                  w_wr_ok;
  logic                  w_alloc_ok;
  logic                  w_rd_en   [NUM_RD];
  logic [ADDR_W-1:0]     w_rd_addr [NUM_RD];
  logic [DATA_WIDTH-1:0] w_rd_data [NUM_RD];
  logic                  w_rd_rdy  [NUM_RD];

  assign w_wr_ok    = wr_en_i    && (wr_addr_i    != ADDR_W'(PREG_ZERO));
  assign w_alloc_ok = alloc_en_i && (alloc_addr_i != ADDR_W'(PREG_ZERO));

  // Alloc is applied after write so it wins the ready bit on a same-index collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
      r_ready <= '1;
    end else begin
      if (w_wr_ok) begin
        r_mem[wr_addr_i]   <= wr_data_i;
        r_ready[wr_addr_i] <= 1'b1;
      end
      if (w_alloc_ok) begin
        r_ready[alloc_addr_i] <= 1'b0;
      end
    end
  end

  assign w_rd_en[0]   = rd1_en_i;
  assign w_rd_en[1]   = rd2_en_i;
  assign w_rd_en[2]   = rd3_en_i;
  assign w_rd_addr[0] = rd1_addr_i;
  assign w_rd_addr[1] = rd2_addr_i;
  assign w_rd_addr[2] = rd3_addr_i;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    prf_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (ADDR_W)
    ) u_port (
      .clk          (clk),
      .rst          (rst),
      .rd_en_i      (w_rd_en[g]),
      .rd_addr_i    (w_rd_addr[g]),
      .arr_data_i   (r_mem[w_rd_addr[g]]),
      .arr_ready_i  (r_ready[w_rd_addr[g]]),
      .wr_en_i      (wr_en_i),
      .wr_addr_i    (wr_addr_i),
      .wr_data_i    (wr_data_i),
      .alloc_en_i   (alloc_en_i),
      .alloc_addr_i (alloc_addr_i),
      .rd_data_o    (w_rd_data[g]),
      .rd_ready_o   (w_rd_rdy[g])
    );
  end

  assign rd1_data_o  = w_rd_data[0];
  assign rd1_ready_o = w_rd_rdy[0];
  assign rd2_data_o  = w_rd_data[1];
  assign rd2_ready_o = w_rd_rdy[1];
  assign rd3_data_o  = w_rd_data[2];
  assign rd3_ready_o = w_rd_rdy[2];

endmodule

// File: tb/tb_prf_1w_3r.sv
// Directed self-checking bench for prf_1w_3r; expectations follow PRF_WR_BYPASS_EN.
module tb_prf_1w_3r;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          alloc_en_i;
  logic [AW-1:0] alloc_addr_i;
  logic          rd1_en_i, rd2_en_i, rd3_en_i;
  logic [AW-1:0] rd1_addr_i, rd2_addr_i, rd3_addr_i;
  logic [DW-1:0] rd1_data_o, rd2_data_o, rd3_data_o;
  logic          rd1_ready_o, rd2_ready_o, rd3_ready_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prf_1w_3r dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .alloc_en_i   (alloc_en_i),
    .alloc_addr_i (alloc_addr_i),
    .rd1_en_i     (rd1_en_i),
    .rd1_addr_i   (rd1_addr_i),
    .rd1_data_o   (rd1_data_o),
    .rd1_ready_o  (rd1_ready_o),
    .rd2_en_i     (rd2_en_i),
    .rd2_addr_i   (rd2_addr_i),
    .rd2_data_o   (rd2_data_o),
    .rd2_ready_o  (rd2_ready_o),
    .rd3_en_i     (rd3_en_i),
    .rd3_addr_i   (rd3_addr_i),
    .rd3_data_o   (rd3_data_o),
    .rd3_ready_o  (rd3_ready_o)
  );

  task automatic idle();
    wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    alloc_en_i = 1'b0; alloc_addr_i = '0;
    rd1_en_i = 1'b0; rd2_en_i = 1'b0; rd3_en_i = 1'b0;
    rd1_addr_i = '0; rd2_addr_i = '0; rd3_addr_i = '0;
  endtask

  // Apply the currently driven inputs across one rising edge; outputs sampled after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    vectors++;
    if ({rd1_data_o, rd1_ready_o, rd2_data_o, rd2_ready_o, rd3_data_o, rd3_ready_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rd1=%h/%b rd2=%h/%b rd3=%h/%b, required all 0",
               rd1_data_o, rd1_ready_o, rd2_data_o, rd2_ready_o, rd3_data_o, rd3_ready_o);
    end
    rst = 1'b1;
    rd1_en_i = 1'b1; rd1_addr_i = 6'd5;
    rd2_en_i = 1'b1; rd2_addr_i = 6'd0;
    rd3_en_i = 1'b1; rd3_addr_i = 6'd63;
    step();
    vectors++;
    if ({rd1_data_o, rd1_ready_o, rd2_data_o, rd2_ready_o, rd3_data_o, rd3_ready_o}
        !== {32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_read_5_0_63: rd1=%h/%b rd2=%h/%b rd3=%h/%b, required 0/1 on all",
               rd1_data_o, rd1_ready_o, rd2_data_o, rd2_ready_o, rd3_data_o, rd3_ready_o);
    end
    idle();
  endtask

  task automatic test_write_read();
    wr_en_i = 1'b1; wr_addr_i = 6'd7; wr_data_i = 32'hDEADBEEF;
    step();
    idle();
    rd1_en_i = 1'b1; rd1_addr_i = 6'd7;
    rd2_en_i = 1'b1; rd2_addr_i = 6'd7;
    rd3_en_i = 1'b1; rd3_addr_i = 6'd7;
    step();
    vectors++;
    if ({rd1_data_o, rd1_ready_o, rd2_data_o, rd2_ready_o, rd3_data_o, rd3_ready_o}
        !== {32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1}) begin
      miscompares++;
      $display("FAIL write_read_7: rd1=%h/%b rd2=%h/%b rd3=%h/%b, required deadbeef/1 on all",
               rd1_data_o, rd1_ready_o, rd2_data_o, rd2_ready_o, rd3_data_o, rd3_ready_o);
    end
  endtask

  task automatic test_disable();
    rd1_en_i = 1'b0;
    step();
    vectors++;
    if ({rd1_data_o, rd1_ready_o} !== {32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL rd1_disabled: got %h/%b, required 0/0", rd1_data_o, rd1_ready_o);
    end
    vectors++;
    if ({rd2_data_o, rd2_ready_o} !== {32'hDEADBEEF, 1'b1}) begin
      miscompares++;
      $display("FAIL rd2_still_enabled: got %h/%b, required deadbeef/1", rd2_data_o, rd2_ready_o);
    end
    idle();
  endtask

  task automatic test_alloc_write();
    alloc_en_i = 1'b1; alloc_addr_i = 6'd12;
    step();
    idle();
    rd1_en_i = 1'b1; rd1_addr_i = 6'd12;
    step();
    vectors++;
    if ({rd1_data_o, rd1_ready_o} !== {32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL alloc_12: got %h/%b, required 0/0", rd1_data_o, rd1_ready_o);
    end
    idle();
    wr_en_i = 1'b1; wr_addr_i = 6'd12; wr_data_i = 32'h55;
    step();
    idle();
    rd1_en_i = 1'b1; rd1_addr_i = 6'd12;
    step();
    vectors++;
    if ({rd1_data_o, rd1_ready_o} !== {32'h55, 1'b1}) begin
      miscompares++;
      $display("FAIL write_after_alloc_12: got %h/%b, required 55/1", rd1_data_o, rd1_ready_o);
    end
    idle();
    wr_en_i = 1'b1; wr_addr_i = 6'd12; wr_data_i = 32'h55;
    alloc_en_i = 1'b1; alloc_addr_i = 6'd12;
    step();
    idle();
    rd3_en_i = 1'b1; rd3_addr_i = 6'd12;
    step();
    vectors++;
    if ({rd3_data_o, rd3_ready_o} !== {32'h55, 1'b0}) begin
      miscompares++;
      $display("FAIL alloc_wins_12: got %h/%b, required 55/0", rd3_data_o, rd3_ready_o);
    end
    idle();
  endtask

  task automatic test_alloc_read_same_cycle();
    wr_en_i = 1'b1; wr_addr_i = 6'd20; wr_data_i = 32'h2020;
    step();
    idle();
    alloc_en_i = 1'b1; alloc_addr_i = 6'd20;
    rd2_en_i = 1'b1; rd2_addr_i = 6'd20;
    step();
    vectors++;
    if ({rd2_data_o, rd2_ready_o} !== {32'h2020, 1'b1}) begin
      miscompares++;
      $display("FAIL alloc_read_pre_ready: got %h/%b, required 2020/1", rd2_data_o, rd2_ready_o);
    end
    idle();
    rd2_en_i = 1'b1; rd2_addr_i = 6'd20;
    step();
    vectors++;
    if ({rd2_data_o, rd2_ready_o} !== {32'h2020, 1'b0}) begin
      miscompares++;
      $display("FAIL alloc_read_post_ready: got %h/%b, required 2020/0", rd2_data_o, rd2_ready_o);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    wr_en_i = 1'b1; wr_addr_i = 6'd0; wr_data_i = 32'h1234;
    alloc_en_i = 1'b1; alloc_addr_i = 6'd0;
    rd1_en_i = 1'b1; rd1_addr_i = 6'd0;
    step();
    vectors++;
    if ({rd1_data_o, rd1_ready_o} !== {32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL zero_same_cycle: got %h/%b, required 0/1", rd1_data_o, rd1_ready_o);
    end
    idle();
    rd1_en_i = 1'b1; rd1_addr_i = 6'd0;
    rd2_en_i = 1'b1; rd2_addr_i = 6'd0;
    step();
    vectors++;
    if ({rd1_data_o, rd1_ready_o, rd2_data_o, rd2_ready_o} !== {32'h0, 1'b1, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL zero_after: rd1=%h/%b rd2=%h/%b, required 0/1",
               rd1_data_o, rd1_ready_o, rd2_data_o, rd2_ready_o);
    end
    idle();
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_d;
    logic          exp_r;
    wr_en_i = 1'b1; wr_addr_i = 6'd9; wr_data_i = 32'h11;
    step();
    idle();
    alloc_en_i = 1'b1; alloc_addr_i = 6'd9;
    step();
    idle();
    wr_en_i = 1'b1; wr_addr_i = 6'd9; wr_data_i = 32'hA5A5A5A5;
    rd2_en_i = 1'b1; rd2_addr_i = 6'd9;
`ifdef PRF_WR_BYPASS_EN
    exp_d = 32'hA5A5A5A5; exp_r = 1'b1;
`else
    exp_d = 32'h11; exp_r = 1'b0;
`endif
    step();
    vectors++;
    if ({rd2_data_o, rd2_ready_o} !== {exp_d, exp_r}) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got %h/%b, required %h/%b", rd2_data_o, rd2_ready_o, exp_d, exp_r);
    end
    idle();
    rd2_en_i = 1'b1; rd2_addr_i = 6'd9;
    step();
    vectors++;
    if ({rd2_data_o, rd2_ready_o} !== {32'hA5A5A5A5, 1'b1}) begin
      miscompares++;
      $display("FAIL bypass_next_cycle: got %h/%b, required a5a5a5a5/1", rd2_data_o, rd2_ready_o);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    wr_en_i = 1'b1; wr_addr_i = 6'd30; wr_data_i = 32'h1;
    step();
    wr_data_i = 32'h2;
    step();
    idle();
    rd3_en_i = 1'b1; rd3_addr_i = 6'd30;
    step();
    vectors++;
    if ({rd3_data_o, rd3_ready_o} !== {32'h2, 1'b1}) begin
      miscompares++;
      $display("FAIL back_to_back_30: got %h/%b, required 2/1", rd3_data_o, rd3_ready_o);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    wr_en_i = 1'b1; wr_addr_i = 6'd3; wr_data_i = 32'h33;
    alloc_en_i = 1'b1; alloc_addr_i = 6'd4;
    step();
    idle();
    rst = 1'b0;
    wr_en_i = 1'b1; wr_addr_i = 6'd3; wr_data_i = 32'h99;
    rd1_en_i = 1'b1; rd1_addr_i = 6'd3;
    step();
    vectors++;
    if ({rd1_data_o, rd1_ready_o} !== {32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL read_dropped_in_reset: got %h/%b, required 0/0", rd1_data_o, rd1_ready_o);
    end
    idle();
    rst = 1'b1;
    rd1_en_i = 1'b1; rd1_addr_i = 6'd3;
    rd2_en_i = 1'b1; rd2_addr_i = 6'd4;
    rd3_en_i = 1'b1; rd3_addr_i = 6'd7;
    step();
    vectors++;
    if ({rd1_data_o, rd1_ready_o, rd2_data_o, rd2_ready_o, rd3_data_o, rd3_ready_o}
        !== {32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL post_reset_3_4_7: rd1=%h/%b rd2=%h/%b rd3=%h/%b, required 0/1 on all",
               rd1_data_o, rd1_ready_o, rd2_data_o, rd2_ready_o, rd3_data_o, rd3_ready_o);
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_disable();
    test_alloc_write();
    test_alloc_read_same_cycle();
    test_zero_reg();
    test_bypass();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prf_1w_3r.md
# prf_1w_3r

Physical register file for the out-of-order core: one writeback port, three registered read ports, and a per-register ready bit. Rename allocation clears the ready bit; writeback sets it. The three read ports serve issue-stage operand fetch (rs1, rs2, and a third operand for stores and branches). It is the read-side counterpart of the single-read, multi-write flip-flop used elsewhere in the datapath.

## Interface
Parameters:
- DATA_WIDTH, 32, register width
- NUM_REGS, 64, number of physical registers (power of two, ≥ 4)
- ADDR_W, $clog2(NUM_REGS), register index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- wr_en_i  in  1  writeback strobe
- wr_addr_i  in  ADDR_W  writeback register index
- wr_data_i  in  DATA_WIDTH  writeback data
- alloc_en_i  in  1  rename allocation strobe
- alloc_addr_i  in  ADDR_W  index being allocated (its ready bit is cleared)
- rdN_en_i  in  1  read request, N = 1..3
- rdN_addr_i  in  ADDR_W  read index, N = 1..3
- rdN_data_o  out  DATA_WIDTH  registered read data, N = 1..3
- rdN_ready_o  out  1  registered ready bit of the register read, N = 1..3

## Operation
- Storage: NUM_REGS × DATA_WIDTH data array plus NUM_REGS ready bits.
- Register 0 is hardwired: reads return 0 with ready = 1. Writes and allocs to index 0 are ignored.
- Write: when wr_en_i = 1 and wr_addr_i ≠ 0, mem[wr_addr_i] ← wr_data_i and ready[wr_addr_i] ← 1.
- Alloc: when alloc_en_i = 1 and alloc_addr_i ≠ 0, ready[alloc_addr_i] ← 0. The data is left unchanged.
- Write and alloc to the same index in the same cycle: the data is written, and the ready bit ends at 0 (alloc wins).
- Read port N, with rdN_en_i = 1: on the next edge, rdN_data_o ← value of the index and rdN_ready_o ← its ready bit.
- Read port N, with rdN_en_i = 0: on the next edge, rdN_data_o ← 0 and rdN_ready_o ← 0.
- All three ports are independent. Identical addresses on multiple ports are legal and must return identical results.
- Reset (rst = 0 at an edge): all data ← 0, ready[i] ← 1 for all i, all rdN_data_o ← 0, all rdN_ready_o ← 0. Reset overrides any concurrent write, alloc, or read. A read issued in the reset cycle is dropped.

## Timing
- Write latency: data is visible to a read issued in the cycle after wr_en_i.
- Read latency: 1 cycle from rdN_en_i to rdN_data_o / rdN_ready_o. There is no handshake; a read request is accepted every cycle.
- Same-cycle write/read of the same index is governed by the Configuration macro.
- Same-cycle alloc/read of the same index: the read returns the pre-alloc ready bit.
- Back-to-back writes to the same index: the last write wins and ready stays 1.

## Configuration
- PRF_WR_BYPASS_EN defined: when the write and read target the same nonzero index in the same cycle, the read returns wr_data_i and ready = 1. If alloc to the same index also occurs that cycle, ready = 0.
- PRF_WR_BYPASS_EN undefined: such a read returns the pre-write array contents and pre-write ready bit. The writeback stage must then delay dependent issue by one cycle.

## Structure
- Shared package prf_pkg:
  - default DATA_WIDTH and NUM_REGS constants
  - typedef preg_idx_t (ADDR_W-wide index)
  - typedef preg_data_t
  - constant PREG_ZERO = 0
- Sub-module prf_read_port, instantiated three times. It contains the address compare, the bypass mux under PRF_WR_BYPASS_EN, the zero-register override, the enable gating, and the output registers.

## Test plan
- Reset: hold rst = 0 for 2 cycles, release, read indices 5, 0, 63 → all data 0; ready = 1, 1, 1 one cycle after the request.
- Write then read: write 0xDEADBEEF to index 7; next cycle read 7 on all three ports → all return 0xDEADBEEF with ready = 1 after 1 cycle.
- Alloc/write pairing: alloc 12 → read 12 gives ready = 0; then write 0x55 to 12 → read gives 0x55, ready = 1. Alloc and write 12 in the same cycle → read gives 0x55, ready = 0.
- Zero register: write 0x1234 to index 0 and alloc 0 → read 0 returns 0, ready = 1.
- Bypass: write 0xA5A5A5A5 to 9 while rd2 reads 9 in the same cycle → with PRF_WR_BYPASS_EN, rd2_data_o = 0xA5A5A5A5; without it, rd2_data_o returns the prior value.
- Disable and mid-reset: rd1_en_i = 0 → rd1_data_o = 0 next cycle. Assert rst during a write to 3 → read 3 after release returns 0, ready = 1.
